// File: rtl/riscv_ifetch.sv
// Instruction fetch stage: sequential PC generation, in-order imem request/response, FWFT queue to decode.
// Optional performance counters are compiled in when RISCV_IFETCH_PERF_EN is defined.
module riscv_ifetch #(
  parameter int              XLEN       = 64,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_err_o
`ifdef RISCV_IFETCH_PERF_EN
  ,
  output logic [63:0]     perf_fetched_o,
  output logic [31:0]     perf_redirect_o,
  output logic [31:0]     perf_drop_o
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_pc_al;
  logic [CW-1:0]   q_count, outstanding, outstanding_nxt, drop_cnt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            started, req_hold;
  logic            req_hs, push, pop, credit, full;

  logic [31:0]     q_data [FIFO_DEPTH];
  logic [XLEN-1:0] q_pc   [FIFO_DEPTH];
  logic            q_err  [FIFO_DEPTH];

  assign redirect_pc_al  = redirect_pc_i & ~XLEN'(3);
  // Credit uses registered counts only, so a pop or response this cycle frees a slot next cycle.
  assign credit          = (SW'(q_count) + SW'(outstanding)) < SW'(FIFO_DEPTH);
  assign full            = (q_count == CW'(FIFO_DEPTH));
  assign req_hs          = imem_req_valid_o && imem_req_ready_i;
  assign outstanding_nxt = outstanding + CW'(req_hs) - CW'(imem_rsp_valid_i);
  assign push            = imem_rsp_valid_i && (drop_cnt == '0) && !redirect_i;
  assign inst_valid_o    = (q_count != '0);
  assign pop             = inst_valid_o && inst_ready_i && !redirect_i;

  assign inst_o    = inst_valid_o ? q_data[rd_ptr] : '0;
  assign inst_pc_o = inst_valid_o ? q_pc[rd_ptr]   : '0;
  assign inst_err_o = inst_valid_o ? q_err[rd_ptr] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: state_nxt = FETCH;
      DRAIN: if (drop_cnt == '0 || (drop_cnt == CW'(1) && imem_rsp_valid_i)) state_nxt = FETCH;
      HALT:  state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
    if (push && imem_rsp_err_i) state_nxt = HALT;
    if (redirect_i) state_nxt = (outstanding_nxt != '0) ? DRAIN : FETCH;
  end

  // A request left pending when a fault halts fetch is still held until it handshakes.
  always_comb begin
    imem_req_valid_o = 1'b0;
    case (state)
      FETCH:   imem_req_valid_o = started && credit;
      HALT:    imem_req_valid_o = req_hold;
      default: imem_req_valid_o = 1'b0;
    endcase
    imem_req_addr_o = fetch_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      q_count     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      started     <= 1'b0;
      req_hold    <= 1'b0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_nxt;
      req_hold    <= imem_req_valid_o && !imem_req_ready_i && !redirect_i;
      if (redirect_i) begin
        fetch_pc <= redirect_pc_al;
        rsp_pc   <= redirect_pc_al;
        drop_cnt <= outstanding_nxt;
        q_count  <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_hs) fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid_i && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage carries data only; validity lives in q_count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_rsp_data_i;
      q_pc[wr_ptr]   <= rsp_pc;
      q_err[wr_ptr]  <= imem_rsp_err_i;
    end
  end

  push_not_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

`ifdef RISCV_IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_o  <= '0;
      perf_redirect_o <= '0;
      perf_drop_o     <= '0;
    end else begin
      if (pop) perf_fetched_o <= perf_fetched_o + 64'd1;
      if (redirect_i) perf_redirect_o <= perf_redirect_o + 32'd1;
      if (imem_rsp_valid_i && (drop_cnt != '0 || redirect_i)) perf_drop_o <= perf_drop_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/riscv_ifetch.md
Name: riscv_ifetch

Overview:
Instruction fetch stage directly upstream of the RV64 decoder. Generates sequential PCs and issues word requests to the instruction memory over a valid/ready request channel with an in-order response channel. Buffers returned instruction words with their PCs in a small first-word-fall-through queue and presents them to decode over a valid/ready handshake. Handles redirects (branch, jump, exception) by flushing buffered and in-flight fetches.

Parameters:
XLEN, 64, PC and address width
FIFO_DEPTH, 4, instruction queue entries; also the cap on queued plus in-flight fetches; power of two, at least 2
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  XLEN  fetch address, always 4-byte aligned
imem_rsp_valid_i  in  1  response valid; in order, one per accepted request, never back-pressured
imem_rsp_data_i  in  32  instruction word
imem_rsp_err_i  in  1  access fault on this fetch
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  XLEN  restart address; bits [1:0] ignored and forced to 0
inst_valid_o  out  1  queue head valid
inst_ready_i  in  1  decode accepts head
inst_o  out  32  head instruction word
inst_pc_o  out  XLEN  head PC
inst_err_o  out  1  head fetch faulted

Behaviour:
- Reset is asynchronous and active-high. Reset values: fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; state=FETCH. All outputs are 0, except imem_req_addr_o, which shows RESET_PC.
- FSM states: FETCH, DRAIN, HALT.
- FETCH:
  - imem_req_valid_o=1 when queue_count+outstanding < FIFO_DEPTH.
  - A pop in the same cycle is not credited until the next cycle.
  - imem_req_addr_o=fetch_pc.
  - On request handshake: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
- Request stability: once imem_req_valid_o is high without ready, it and the address hold until handshake, except when redirect_i is high.
- Responses:
  - Each response decrements outstanding.
  - If drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Otherwise: push {data, err, pc}. The PC comes from a response-PC register that advances by 4 per pushed entry.
  - Queue overflow cannot occur by construction; assertion: push never occurs when full.
- Error response: the entry is pushed with err=1 and the state goes to HALT. HALT issues no requests until redirect.
- Redirect (redirect_i=1), in any state, takes effect at the clock edge:
  - Queue flushed; a simultaneous pop is ignored and a simultaneous push is discarded.
  - fetch_pc and the response-PC register are loaded with {redirect_pc_i[XLEN-1:2],2'b00}.
  - drop_cnt is set to outstanding after this cycle's updates: a request accepted this cycle is counted, a response arriving this cycle is excluded.
  - Next state: DRAIN if that count is nonzero, else FETCH.
- DRAIN: no requests issued; go to FETCH on the cycle drop_cnt reaches 0.
- Redirect mid-DRAIN reloads drop_cnt with the current outstanding count. Redirect in HALT restarts normally.
- Latency:
  - Request handshake to next PC on imem_req_addr_o: 1 cycle.
  - Response cycle N gives inst_valid_o at N+1.
  - First request after reset: the cycle after rst deasserts.
- Output handshake: inst_valid_o = queue not empty. Head fields are stable while valid and not ready. A pop occurs on valid&&ready. Push and pop are simultaneous-safe.
- No outstanding counter wrap: width $clog2(FIFO_DEPTH+1), bounded by the credit rule.

Optional Feature:
- Macro RISCV_IFETCH_PERF_EN.
- Defined:
  - Adds output perf_fetched_o (64 bits): count of instructions popped by decode.
  - Adds output perf_redirect_o (32 bits): count of redirects.
  - Adds output perf_drop_o (32 bits): count of discarded responses.
  - All counters reset to 0 and wrap silently.
- Undefined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Reset release, memory always ready, 1-cycle response, decode always ready -> requests at 0x80000000, 0x80000004, 0x80000008, ...; inst_pc_o sequence matches; one instruction per cycle sustained.
- inst_ready_i held 0, FIFO_DEPTH=4 -> exactly 4 requests issued and 4 entries queued. Raise ready -> PCs 0x80000000..0x8000000C popped in order, then fetch resumes at 0x80000010.
- 2 requests outstanding, redirect_i with redirect_pc_i=0x80001002 -> DRAIN; both responses discarded; next request addr 0x80001000; first inst_pc_o is 0x80001000.
- Redirect in the same cycle as a response and a pop -> queue empty next cycle; response not delivered; drop_cnt excludes it.
- Response with imem_rsp_err_i=1 at PC 0x80000008 -> entry delivered with inst_err_o=1, no further requests. Redirect to 0x80000100 -> fetch resumes there.
- rst asserted mid-DRAIN with 3 outstanding -> all outputs immediately 0 (addr 0x80000000). After release, responses from old requests must not be sent by the memory model (bench resets both).
